// File: rtl/demux4_buffered_if.sv
// Handshake bundle for demux4_buffered: one valid/ready input stream and
// four independent valid/ready output channels with per-channel full flags.
interface demux4_buffered_if #(
   parameter int WIDTH_DATA_LENGTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [1:0]                   sel_port;
   logic [WIDTH_DATA_LENGTH-1:0] port_in;

   logic [WIDTH_DATA_LENGTH-1:0] port_out_0;
   logic [WIDTH_DATA_LENGTH-1:0] port_out_1;
   logic [WIDTH_DATA_LENGTH-1:0] port_out_2;
   logic [WIDTH_DATA_LENGTH-1:0] port_out_3;
   logic                         out_valid_0;
   logic                         out_valid_1;
   logic                         out_valid_2;
   logic                         out_valid_3;
   logic                         out_ready_0;
   logic                         out_ready_1;
   logic                         out_ready_2;
   logic                         out_ready_3;
   logic                         full_0;
   logic                         full_1;
   logic                         full_2;
   logic                         full_3;

   // Producer and consumers together form the master side.
   modport master (
      output in_valid, sel_port, port_in,
      output out_ready_0, out_ready_1, out_ready_2, out_ready_3,
      input  in_ready,
      input  port_out_0, port_out_1, port_out_2, port_out_3,
      input  out_valid_0, out_valid_1, out_valid_2, out_valid_3,
      input  full_0, full_1, full_2, full_3
   );

   modport slave (
      input  in_valid, sel_port, port_in,
      input  out_ready_0, out_ready_1, out_ready_2, out_ready_3,
      output in_ready,
      output port_out_0, port_out_1, port_out_2, port_out_3,
      output out_valid_0, out_valid_1, out_valid_2, out_valid_3,
      output full_0, full_1, full_2, full_3
   );
endinterface

// File: rtl/demux4_buffered.sv
// Registered 1-to-4 demultiplexer: each word is steered by sel_port into one of
// four small FIFOs so a stalled consumer never blocks the other channels.
module demux4_buffered #(
   parameter int WIDTH_DATA_LENGTH = 8,
   parameter int FIFO_DEPTH        = 2
) (
   input logic              clk,
   input logic              rst,
   demux4_buffered_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [3:0]                   out_ready_s;
   logic [3:0]                   push_s;
   logic [3:0]                   pop_s;
   logic [3:0]                   full_s;
   logic [3:0]                   valid_s;
   logic [WIDTH_DATA_LENGTH-1:0] head_s [4];
   logic                         in_ready_s;

   assign out_ready_s = {bus.out_ready_3, bus.out_ready_2, bus.out_ready_1, bus.out_ready_0};

   // Acceptance looks only at the selected channel's registered fill level,
   // so no consumer ready can ripple back to the producer.
   assign in_ready_s = ~full_s[bus.sel_port];

   for (genvar k = 0; k < 4; k++) begin : g_ch
      logic [WIDTH_DATA_LENGTH-1:0] mem_r [FIFO_DEPTH];
      logic [PTR_W-1:0]             wr_ptr_r;
      logic [PTR_W-1:0]             rd_ptr_r;
      logic [CNT_W-1:0]             count_r;

      assign full_s[k]  = (count_r == CNT_W'(FIFO_DEPTH));
      assign valid_s[k] = (count_r != {CNT_W{1'b0}});
      assign push_s[k]  = bus.in_valid & in_ready_s & (bus.sel_port == 2'(k));
      assign pop_s[k]   = valid_s[k] & out_ready_s[k];
      assign head_s[k]  = mem_r[rd_ptr_r];

      // Channel FIFO state: storage, pointers and occupancy count.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               mem_r[i] <= {WIDTH_DATA_LENGTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
         end else begin
            if (push_s[k]) begin
               mem_r[wr_ptr_r] <= bus.port_in;
               wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s[k]) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s[k], pop_s[k]})
               2'b10:   count_r <= count_r + CNT_W'(1);
               2'b01:   count_r <= count_r - CNT_W'(1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.port_out_0  = head_s[0];
   assign bus.port_out_1  = head_s[1];
   assign bus.port_out_2  = head_s[2];
   assign bus.port_out_3  = head_s[3];
   assign bus.out_valid_0 = valid_s[0];
   assign bus.out_valid_1 = valid_s[1];
   assign bus.out_valid_2 = valid_s[2];
   assign bus.out_valid_3 = valid_s[3];
   assign bus.full_0      = full_s[0];
   assign bus.full_1      = full_s[1];
   assign bus.full_2      = full_s[2];
   assign bus.full_3      = full_s[3];
endmodule

// File: tb/tb_demux4_buffered.sv
// Self-checking bench for demux4_buffered: directed vector table, hand-written
// reset and wrap sequences, then random traffic against a queue-based model.
module tb_demux4_buffered;
   localparam int W = 8;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux4_buffered_if #(.WIDTH_DATA_LENGTH(W)) bus ();

   demux4_buffered #(.WIDTH_DATA_LENGTH(W), .FIFO_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        iv;
      logic [1:0]  sel;
      logic [7:0]  din;
      logic [3:0]  ordy;
      logic        exp_ir;
      logic [3:0]  exp_ov;
      logic [3:0]  exp_full;
      logic [31:0] exp_d;   // {d3,d2,d1,d0}, compared only where exp_ov is set
   } vec_t;

   vec_t       tbl [30];
   logic [7:0] q [4][$];
   logic       hold;
   logic       r_iv;
   logic [1:0] r_sel;
   logic [7:0] r_din;
   logic [3:0] r_ordy;
   logic       exp_ir;
   logic [7:0] exp_byte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] ov_v();
      return {bus.out_valid_3, bus.out_valid_2, bus.out_valid_1, bus.out_valid_0};
   endfunction

   function automatic logic [3:0] full_v();
      return {bus.full_3, bus.full_2, bus.full_1, bus.full_0};
   endfunction

   function automatic logic [7:0] dout(input int k);
      case (k)
         0:       return bus.port_out_0;
         1:       return bus.port_out_1;
         2:       return bus.port_out_2;
         default: return bus.port_out_3;
      endcase
   endfunction

   task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] din,
                        input logic [3:0] ordy);
      bus.in_valid    = iv;
      bus.sel_port    = sel;
      bus.port_in     = din;
      bus.out_ready_0 = ordy[0];
      bus.out_ready_1 = ordy[1];
      bus.out_ready_2 = ordy[2];
      bus.out_ready_3 = ordy[3];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // iv sel din ordy | ir ov full data
      tbl[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'h1, 4'h0, 32'h000000A0};
      tbl[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'h2, 4'h0, 32'h0000A100};
      tbl[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'h4, 4'h0, 32'h00A20000};
      tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h8, 4'h0, 32'hA3000000};
      tbl[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[6]  = '{1'b1, 2'd1, 8'h11, 4'hD, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[7]  = '{1'b1, 2'd1, 8'h22, 4'hD, 1'b1, 4'h2, 4'h0, 32'h00001100};
      tbl[8]  = '{1'b1, 2'd1, 8'h33, 4'hD, 1'b0, 4'h2, 4'h2, 32'h00001100};
      tbl[9]  = '{1'b1, 2'd1, 8'h33, 4'hD, 1'b0, 4'h2, 4'h2, 32'h00001100};
      tbl[10] = '{1'b1, 2'd1, 8'h33, 4'hF, 1'b0, 4'h2, 4'h2, 32'h00001100};
      tbl[11] = '{1'b1, 2'd1, 8'h33, 4'hF, 1'b1, 4'h2, 4'h0, 32'h00002200};
      tbl[12] = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'h2, 4'h0, 32'h00003300};
      tbl[13] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[14] = '{1'b1, 2'd3, 8'hC0, 4'h7, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[15] = '{1'b1, 2'd3, 8'hC1, 4'h7, 1'b1, 4'h8, 4'h0, 32'hC0000000};
      tbl[16] = '{1'b1, 2'd3, 8'hC2, 4'hF, 1'b0, 4'h8, 4'h8, 32'hC0000000};
      tbl[17] = '{1'b1, 2'd3, 8'hC2, 4'h7, 1'b1, 4'h8, 4'h0, 32'hC1000000};
      tbl[18] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b0, 4'h8, 4'h8, 32'hC1000000};
      tbl[19] = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 4'h8, 4'h0, 32'hC2000000};
      tbl[20] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[21] = '{1'b1, 2'd0, 8'hD0, 4'hE, 1'b1, 4'h0, 4'h0, 32'h00000000};
      tbl[22] = '{1'b1, 2'd0, 8'hD1, 4'hE, 1'b1, 4'h1, 4'h0, 32'h000000D0};
      tbl[23] = '{1'b1, 2'd2, 8'h5C, 4'hE, 1'b1, 4'h1, 4'h1, 32'h000000D0};
      tbl[24] = '{1'b1, 2'd0, 8'hD2, 4'hE, 1'b0, 4'h5, 4'h1, 32'h005C00D0};
      tbl[25] = '{1'b1, 2'd0, 8'hD2, 4'hE, 1'b0, 4'h1, 4'h1, 32'h000000D0};
      tbl[26] = '{1'b1, 2'd0, 8'hD2, 4'hF, 1'b0, 4'h1, 4'h1, 32'h000000D0};
      tbl[27] = '{1'b1, 2'd0, 8'hD2, 4'hF, 1'b1, 4'h1, 4'h0, 32'h000000D1};
      tbl[28] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h1, 4'h0, 32'h000000D2};
      tbl[29] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 4'h0, 32'h00000000};

      drive(1'b0, 2'd0, 8'h00, 4'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
      chk("reset_out_valid", 32'(ov_v()), 32'h0);
      chk("reset_full", 32'(full_v()), 32'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("reset_port_out%0d", k), 32'(dout(k)), 32'h0);
      rst = 1'b0;

      // Directed vector table: routing, fill/stall, full-with-pop, head-of-line.
      for (int i = 0; i < 30; i++) begin
         drive(tbl[i].iv, tbl[i].sel, tbl[i].din, tbl[i].ordy);
         #1;
         chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_ir));
         chk($sformatf("tbl%0d_out_valid", i), 32'(ov_v()), 32'(tbl[i].exp_ov));
         chk($sformatf("tbl%0d_full", i), 32'(full_v()), 32'(tbl[i].exp_full));
         for (int k = 0; k < 4; k++) begin
            if (tbl[i].exp_ov[k]) begin
               exp_byte = tbl[i].exp_d[8*k +: 8];
               chk($sformatf("tbl%0d_port_out%0d", i, k), 32'(dout(k)), 32'(exp_byte));
            end
         end
         tick();
      end

      // Asynchronous reset with channel 2 holding two words.
      drive(1'b1, 2'd2, 8'h77, 4'h0);
      tick();
      drive(1'b1, 2'd2, 8'h88, 4'h0);
      tick();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      #1;
      chk("midrst_pre_full", 32'(full_v()), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("midrst_out_valid", 32'(ov_v()), 32'h0);
      chk("midrst_full", 32'(full_v()), 32'h0);
      for (int k = 0; k < 4; k++) chk($sformatf("midrst_port_out%0d", k), 32'(dout(k)), 32'h0);
      tick();
      rst = 1'b0;
      drive(1'b1, 2'd0, 8'h42, 4'h0);
      tick();
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      #1;
      chk("postrst_out_valid", 32'(ov_v()), 32'h1);
      chk("postrst_port_out0", 32'(dout(0)), 32'h42);
      tick();

      // Pointer wrap: ten back-to-back push/pop pairs on channel 0.
      for (int i = 0; i <= 10; i++) begin
         drive(i < 10, 2'd0, 8'(i), 4'hF);
         #1;
         chk($sformatf("wrap%0d_full0", i), 32'(bus.full_0), 32'h0);
         chk($sformatf("wrap%0d_in_ready", i), 32'(bus.in_ready), 32'h1);
         if (i > 0) begin
            chk($sformatf("wrap%0d_valid0", i), 32'(bus.out_valid_0), 32'h1);
            chk($sformatf("wrap%0d_port_out0", i), 32'(dout(0)), 32'(i - 1));
         end
         tick();
      end

      // Random traffic against per-channel queues; a stalled word is held stable.
      hold = 1'b0;
      r_iv = 1'b0;
      r_sel = 2'd0;
      r_din = 8'h00;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            r_iv  = ($urandom_range(0, 3) != 0);
            r_sel = 2'($urandom_range(0, 3));
            r_din = 8'($urandom);
         end
         r_ordy = 4'($urandom);
         drive(r_iv, r_sel, r_din, r_ordy);
         #1;
         exp_ir = (q[r_sel].size() < D);
         chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_ir));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("rnd_valid%0d", k), 32'(ov_v() >> k) & 32'h1, 32'(q[k].size() > 0));
            chk($sformatf("rnd_full%0d", k), 32'(full_v() >> k) & 32'h1, 32'(q[k].size() == D));
            if (q[k].size() > 0) chk($sformatf("rnd_port_out%0d", k), 32'(dout(k)), 32'(q[k][0]));
         end
         for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0 && r_ordy[k]) void'(q[k].pop_front());
         end
         if (r_iv && exp_ir) q[r_sel].push_back(r_din);
         hold = r_iv && !exp_ir;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
